// File: rtl/nibble_tx_pkg.sv
// Shared state encoding and serial line levels for the nibble transmitter.
package nibble_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic TX_IDLE   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/nibble_serial_tx_bit_timer.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// tick_next looks one cycle ahead so the owner can register a pulse that
// lines up with the terminal cycle.
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick,
  output logic tick_next
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Next count: wrap on terminal count, restart on clear.
  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    if (clear || tick) begin
      cnt_nxt = '0;
    end
  end

  assign tick      = (cnt == CNT_LAST);
  assign tick_next = (cnt_nxt == CNT_LAST);

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/nibble_serial_tx.sv
// Parallel-in serial-out transmitter: start bit, DATA_W data bits LSB first,
// stop bit, each held CLKS_PER_BIT clocks. Line idles high.
module nibble_serial_tx
  import nibble_tx_pkg::*;
#(
  parameter int unsigned DATA_W       = 4,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BIT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_END  = BIT_W'(DATA_W);

  tx_state_t         state;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_shr;
  logic [BIT_W-1:0]  bit_cnt;
  logic              clear;
  logic              tick;
  logic              tick_next;

  assign shift_shr = shift >> 1;

  // Baud counter is held at zero while idle and restarted on every state change.
  always_comb begin
    clear = 1'b0;
    case (state)
      IDLE:    clear = 1'b1;
      START:   clear = tick;
      DATA:    clear = tick && (bit_cnt == BIT_LAST);
      STOP:    clear = tick;
      default: clear = 1'b1;
    endcase
  end

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .tick     (tick),
    .tick_next(tick_next)
  );

  // Frame FSM with shift register, bit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      tx      <= TX_IDLE;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= TX_IDLE;
          if (en && ready) begin
            shift   <= d;
            bit_cnt <= '0;
            state   <= START;
            tx      <= START_BIT;
            ready   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            bit_cnt <= '0;
            tx      <= shift[0];
          end
        end
        DATA: begin
          if (tick) begin
            shift <= shift_shr;
            if (bit_cnt == BIT_LAST) begin
              state   <= STOP;
              bit_cnt <= BIT_END;
              tx      <= STOP_BIT;
              // One-clock bits make the first stop cycle the last one.
              done    <= tick_next;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              tx      <= shift_shr[0];
            end
          end
        end
        STOP: begin
          if (tick) begin
            state <= IDLE;
            tx    <= TX_IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else begin
            done <= tick_next;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= TX_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_tx.sv
// Directed bench for nibble_serial_tx: default 4-bit/4-clock instance plus an
// 8-bit/1-clock instance.
module tb_nibble_serial_tx;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] d;
  logic       ready, tx, busy, done;

  logic       en8;
  logic [7:0] d8;
  logic       ready8, tx8, busy8, done8;

  int n_tests = 0;
  int n_fail  = 0;

  nibble_serial_tx u_dut (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .d    (d),
    .ready(ready),
    .tx   (tx),
    .busy (busy),
    .done (done)
  );

  nibble_serial_tx #(
    .DATA_W      (8),
    .CLKS_PER_BIT(1)
  ) u_dut8 (
    .clk  (clk),
    .reset(reset),
    .en   (en8),
    .d    (d8),
    .ready(ready8),
    .tx   (tx8),
    .busy (busy8),
    .done (done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point; 4-state compare so X counts as a miss.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line level in cycle k (1-based after accept) of a 4x4 frame.
  function automatic logic exp_tx4(input logic [3:0] word, input int k);
    int idx;
    idx = (k - 1) / 4;
    if (idx == 0) return 1'b0;
    if (idx == 5) return 1'b1;
    return word[idx-1];
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_tx"},    32'(tx),    32'd1);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_busy"},  32'(busy),  32'd0);
    check({tag, "_done"},  32'(done),  32'd0);
  endtask

  // Entered in cycle 1 of a frame; returns in cycle 25 (first cycle after it).
  task automatic check_frame(input string tag, input logic [3:0] word, input bit hold_en,
                             input logic [3:0] next_d, input int inj_cycle,
                             input logic [3:0] inj_d);
    for (int k = 1; k <= 24; k++) begin
      if (k == 1) begin
        if (hold_en) d = next_d;
        else en = 1'b0;
      end
      if (inj_cycle != 0 && k == inj_cycle) begin
        en = 1'b1;
        d  = inj_d;
      end
      if (inj_cycle != 0 && k == inj_cycle + 1) en = 1'b0;
      check($sformatf("%s_tx_c%0d", tag, k),    32'(tx),    32'(exp_tx4(word, k)));
      check($sformatf("%s_done_c%0d", tag, k),  32'(done),  32'(k == 24));
      check($sformatf("%s_busy_c%0d", tag, k),  32'(busy),  32'd1);
      check($sformatf("%s_ready_c%0d", tag, k), 32'(ready), 32'd0);
      step();
    end
  endtask

  logic exp8 [10];

  initial begin
    exp8 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    reset = 1'b1;
    en    = 1'b0;
    d     = 4'h0;
    en8   = 1'b0;
    d8    = 8'h00;

    // 1: reset, then idle
    step();
    step();
    check_idle("t1_rst");
    check("t1_rst_tx8",    32'(tx8),    32'd1);
    check("t1_rst_ready8", 32'(ready8), 32'd1);
    check("t1_rst_busy8",  32'(busy8),  32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_idle($sformatf("t1_idle%0d", i));
    end

    // 2: single frame of 0001
    en = 1'b1;
    d  = 4'b0001;
    step();
    check_frame("t2", 4'b0001, 1'b0, 4'h0, 0, 4'h0);
    check_idle("t2_end");
    step();
    check_idle("t2_post");

    // 3: en during frame is ignored
    en = 1'b1;
    d  = 4'b1111;
    step();
    check_frame("t3", 4'b1111, 1'b0, 4'h0, 3, 4'b0100);
    for (int i = 0; i < 8; i++) begin
      check_idle($sformatf("t3_after%0d", i));
      step();
    end

    // 4: reset during data bit 2 aborts the frame
    en = 1'b1;
    d  = 4'b0101;
    step();
    en = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      check($sformatf("t4_tx_c%0d", k), 32'(tx), 32'(exp_tx4(4'b0101, k)));
      check($sformatf("t4_busy_c%0d", k), 32'(busy), 32'd1);
      step();
    end
    check("t4_tx_c14", 32'(tx), 32'd1);
    reset = 1'b1;
    step();
    check_idle("t4_rst");
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      check_idle($sformatf("t4_after%0d", i));
    end

    // 5: en held high gives back-to-back frames with one idle cycle
    en = 1'b1;
    d  = 4'b1110;
    step();
    check_frame("t5a", 4'b1110, 1'b1, 4'b0111, 0, 4'h0);
    check_idle("t5_gap");
    step();
    check_frame("t5b", 4'b0111, 1'b0, 4'h0, 0, 4'h0);
    check_idle("t5_end");
    step();
    check_idle("t5_post");

    // 6: 8-bit word at one clock per bit
    en8 = 1'b1;
    d8  = 8'hA5;
    step();
    en8 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("t6_tx_c%0d", k),    32'(tx8),    32'(exp8[k-1]));
      check($sformatf("t6_done_c%0d", k),  32'(done8),  32'(k == 10));
      check($sformatf("t6_busy_c%0d", k),  32'(busy8),  32'd1);
      check($sformatf("t6_ready_c%0d", k), 32'(ready8), 32'd0);
      step();
    end
    check("t6_end_ready", 32'(ready8), 32'd1);
    check("t6_end_busy",  32'(busy8),  32'd0);
    check("t6_end_tx",    32'(tx8),    32'd1);
    check("t6_end_done",  32'(done8),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
